// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read sprite colour ROM between
// several pixel fetchers. Grants are combinational. Each granted address is
// registered to the ROM. The returned byte is routed back to its requester
// exactly two cycles after the grant. A locked requester may hold the ROM for
// a short burst of back-to-back reads.
module sprite_rom_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [2:0]                rd_id
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NUM_EXT   = (IDX_W + 1)'(NUM_REQ);

    // Arbitration state.
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic             owner_vld;
    logic [CNT_W-1:0] count;

    // Return pipeline. Stage 1 is aligned with rom_address; stage 2 is aligned with rom_data.
    logic             v1, v2;
    logic [IDX_W-1:0] id1, id2;

    // Combinational selection results.
    logic             hold;
    logic             any_gnt;
    logic [IDX_W-1:0] sel;
    logic [2*NUM_REQ-1:0] req_rot;
    logic [IDX_W:0]   sum;
    logic [ADDR_W-1:0] sel_addr;

    // Next burst state.
    logic [IDX_W-1:0] owner_n;
    logic             owner_vld_n;
    logic [CNT_W-1:0] count_n;
    logic [CNT_W-1:0] new_count;

    // Pick the winner: the burst owner if it may continue, otherwise the first request at or above ptr.
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        hold    = owner_vld && req[owner] && lock[owner] && (count < BURST_MAX);
        req_rot = {req, req} >> ptr;
        any_gnt = 1'b0;
        sel     = ptr;
        sum     = '0;
        if (hold) begin
            any_gnt = 1'b1;
            sel     = owner;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!any_gnt && req_rot[k]) begin
                    any_gnt = 1'b1;
                    sum     = {1'b0, ptr} + (IDX_W + 1)'(k);
                    if (sum >= NUM_EXT) sum = sum - NUM_EXT;
                    sel     = sum[IDX_W-1:0];
                end
            end
        end
        // No grant is issued while reset is held, even if requests are pending.
        if (!reset_n) any_gnt = 1'b0;
    end

    // One-hot grant, and a mux that reads only the granted address slice.
    always_comb begin
        gnt      = '0;
        sel_addr = '0;
        if (any_gnt) gnt[sel] = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) sel_addr = addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Burst bookkeeping: extend, start, cap or abandon the current lock.
    always_comb begin
        owner_n     = owner;
        owner_vld_n = owner_vld;
        count_n     = count;
        new_count   = '0;
        if (any_gnt) begin
            if (lock[sel]) begin
                new_count = (owner_vld && owner == sel) ? count + CNT_W'(1) : CNT_W'(1);
                if (new_count >= BURST_MAX) begin
                    owner_vld_n = 1'b0;
                    count_n     = '0;
                end else begin
                    owner_vld_n = 1'b1;
                    owner_n     = sel;
                    count_n     = new_count;
                end
            end else begin
                owner_vld_n = 1'b0;
                count_n     = '0;
            end
        end else if (owner_vld && !(req[owner] && lock[owner])) begin
            owner_vld_n = 1'b0;
            count_n     = '0;
        end
    end

    // State, ROM address and return pipeline registers. Reset discards in-flight reads.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr         <= '0;
            owner       <= '0;
            owner_vld   <= 1'b0;
            count       <= '0;
            rom_address <= '0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            id1         <= '0;
            id2         <= '0;
        end else begin
            owner     <= owner_n;
            owner_vld <= owner_vld_n;
            count     <= count_n;
            if (any_gnt) begin
                ptr         <= (sel == LAST_IDX) ? '0 : sel + IDX_W'(1);
                rom_address <= sel_addr;
                id1         <= sel;
            end
            v1  <= any_gnt;
            v2  <= v1;
            id2 <= id1;
        end
    end

    // Return path: ROM data passes straight through, tagged by stage 2.
    always_comb begin
        rd_valid = '0;
        if (v2) rd_valid[id2] = 1'b1;
        rd_data = rom_data;
        rd_id   = 3'(id2);
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter. The driver issues directed
// vectors and checks grants directly. For each grant it queues the expected
// return (id, due cycle, data). A monitor pops the queue and compares each time
// rd_valid is seen.
module tb_sprite_rom_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [35:0] addr;
    logic [3:0]  gnt;
    logic [8:0]  rom_address;
    logic [7:0]  rom_data;
    logic [3:0]  rd_valid;
    logic [7:0]  rd_data;
    logic [2:0]  rd_id;

    logic [7:0]  mem [512];
    logic [35:0] nxt_addr;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int         id;
        int         due;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(9), .DATA_W(8), .MAX_BURST(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .lock        (lock),
        .addr        (addr),
        .gnt         (gnt),
        .rom_address (rom_address),
        .rom_data    (rom_data),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_id       (rd_id)
    );

    always #5 clock = ~clock;

    // Synchronous-read ROM model with one cycle of latency.
    always @(posedge clock) rom_data <= mem[rom_address];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and check the combinational grant.
    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [3:0] eg, input string nm);
        exp_t e;
        int   id;
        @(negedge clock);
        req  = r;
        lock = l;
        addr = nxt_addr;
        #1;
        check(nm, 32'(gnt), 32'(eg));
        if (eg != 4'b0000) begin
            id = 0;
            for (int i = 0; i < 4; i++) if (eg[i]) id = i;
            e.id   = id;
            e.due  = cyc + 2;
            e.data = mem[addr[id*9 +: 9]];
            exp_q.push_back(e);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_rd_valid"}, 32'(rd_valid), 32'h0);
        check({nm, "_rom_address"}, 32'(rom_address), 32'h0);
        check({nm, "_rd_id"}, 32'(rd_id), 32'h0);
        check({nm, "_gnt"}, 32'(gnt), 32'h0);
    endtask

    // Monitor: every return strobe must match the oldest outstanding grant.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n) begin
            if (rd_valid !== 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", 32'(rd_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_cycle", 32'(cyc), 32'(e.due));
                    check("rd_valid", 32'(rd_valid), 32'(1) << e.id);
                    check("rd_id", 32'(rd_id), 32'(e.id));
                    check("rd_data", 32'(rd_data), 32'(e.data));
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                check("rd_missing", 32'(rd_valid), 32'(1) << e.id);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h4F;
        nxt_addr = {9'd40, 9'd30, 9'd20, 9'd10};
        addr     = nxt_addr;
        lock     = 4'b0000;
        req      = 4'b1111;
        reset_n  = 1'b0;

        // Reset held with every line requesting: nothing granted, outputs at reset values.
        repeat (3) begin
            @(negedge clock);
            #1;
            check_reset_outputs("reset_hold");
        end
        req = 4'b0000;
        #1 reset_n = 1'b1;

        // Fairness: all four request, grants rotate 0,1,2,3,0,1,2,3.
        step(4'b1111, 4'b0000, 4'b0001, "fair_g0");
        step(4'b1111, 4'b0000, 4'b0010, "fair_g1");
        step(4'b1111, 4'b0000, 4'b0100, "fair_g2");
        step(4'b1111, 4'b0000, 4'b1000, "fair_g3");
        step(4'b1111, 4'b0000, 4'b0001, "fair_g4");
        step(4'b1111, 4'b0000, 4'b0010, "fair_g5");
        step(4'b1111, 4'b0000, 4'b0100, "fair_g6");
        step(4'b1111, 4'b0000, 4'b1000, "fair_g7");

        // Idle: no grant, ROM address holds the last granted address (requester 3, 40).
        repeat (3) step(4'b0000, 4'b0000, 4'b0000, "idle_gnt");
        check("idle_rom_address", 32'(rom_address), 32'd40);

        // Single requester 2 reading address 65, where the ROM holds 8'h0E.
        nxt_addr[18 +: 9] = 9'd65;
        step(4'b0100, 4'b0000, 4'b0100, "single_gnt");
        step(4'b0000, 4'b0000, 4'b0000, "single_t1_gnt");
        check("single_rom_address", 32'(rom_address), 32'd65);
        step(4'b0000, 4'b0000, 4'b0000, "single_t2_gnt");
        check("single_rd_valid", 32'(rd_valid), 32'h4);
        check("single_rd_id", 32'(rd_id), 32'd2);
        check("single_rd_data", 32'(rd_data), 32'h0E);

        // Move ptr to 1 so requester 1 wins the first arbitration of the burst.
        step(4'b0001, 4'b0000, 4'b0001, "pre_burst_gnt");

        // Burst: requester 1 locked, requester 3 waiting. 8 grants to 1, one to 3, then 1 again.
        nxt_addr[27 +: 9] = 9'd200;
        for (int k = 0; k < 8; k++) begin
            nxt_addr[9 +: 9] = 9'(k);
            step(4'b1010, 4'b0010, 4'b0010, "burst_gnt1");
        end
        nxt_addr[9 +: 9] = 9'd8;
        step(4'b1010, 4'b0010, 4'b1000, "burst_limit_gnt3");
        step(4'b1010, 4'b0010, 4'b0010, "burst_resume_gnt1");
        nxt_addr[9 +: 9] = 9'd9;
        step(4'b1010, 4'b0010, 4'b0010, "burst_resume2_gnt1");
        step(4'b0000, 4'b0000, 4'b0000, "burst_end_gnt");

        // Lock drop: three locked grants to 1, then lock released and 3 wins next.
        step(4'b0001, 4'b0000, 4'b0001, "pre_drop_gnt");
        for (int k = 0; k < 3; k++) begin
            nxt_addr[9 +: 9] = 9'(k);
            step(4'b1010, 4'b0010, 4'b0010, "drop_gnt1");
        end
        nxt_addr[9 +: 9] = 9'd3;
        step(4'b1010, 4'b0000, 4'b1000, "drop_gnt3");
        step(4'b1010, 4'b0000, 4'b0010, "drop_after_gnt1");
        repeat (3) step(4'b0000, 4'b0000, 4'b0000, "drain_gnt");

        // Mid-flight reset: grants in T and T+1, reset pulsed during T+1.
        step(4'b0001, 4'b0000, 4'b0001, "mid_t0_gnt");
        step(4'b0010, 4'b0000, 4'b0010, "mid_t1_gnt");
        #1;
        reset_n = 1'b0;
        req     = 4'b0000;
        exp_q.delete();
        #1;
        check_reset_outputs("mid_in_reset");
        #1 reset_n = 1'b1;
        step(4'b0000, 4'b0000, 4'b0000, "mid_t2_gnt");
        check_reset_outputs("mid_t2");
        step(4'b0000, 4'b0000, 4'b0000, "mid_t3_gnt");
        check_reset_outputs("mid_t3");

        // Arbitration restarts from requester 0 after reset.
        step(4'b1111, 4'b0000, 4'b0001, "post_reset_gnt0");
        step(4'b0000, 4'b0000, 4'b0000, "post_idle_gnt");
        repeat (3) step(4'b0000, 4'b0000, 4'b0000, "final_drain_gnt");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Round-robin arbiter sharing one synchronous-read sprite colour ROM (512 x 8, one-cycle read latency) between several sprite pixel fetchers. Sits between the per-sprite fetch engines and a single ROM instance, issues at most one ROM read per clock and routes each returned byte back to its requester with fixed latency. Supports short locked bursts so a fetcher can read a sprite row back-to-back without interleaving.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 9, ROM address width
- DATA_W, 8, ROM data width
- MAX_BURST, 8, maximum consecutive grants to one locked requester (1..16)
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester read request, level
- lock  in  NUM_REQ  per-requester burst hold; only meaningful with req
- addr  in  NUM_REQ*ADDR_W  request addresses, requester i in bits [i*ADDR_W +: ADDR_W]
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as accepted req
- rom_address  out  ADDR_W  registered address to ROM
- rom_data  in  DATA_W  ROM read data (registered inside ROM)
- rd_valid  out  NUM_REQ  one-hot return strobe
- rd_data  out  DATA_W  returned byte, valid when any rd_valid bit set
- rd_id  out  3  index of requester owning rd_data

## Operation
- Each cycle at most one gnt bit high; gnt[i] high means req[i] and addr slice i are consumed this cycle. Requester may change addr or drop req the cycle after gnt.
- Selection: if burst owner o is set, req[o] and lock[o] high and burst count < MAX_BURST, grant o. Otherwise grant the first requester with req high scanning from pointer ptr upward, wrapping at NUM_REQ-1 -> 0.
- On grant to i: ptr <= (i+1) mod NUM_REQ; if lock[i] high, owner <= i and count <= count+1 (count <= 1 if owner changed); if lock[i] low, owner cleared, count <= 0.
- Burst limit: when count reaches MAX_BURST, owner cleared, count <= 0; next selection is plain round-robin from ptr, so others waiting win before i again.
- Owner also cleared the first cycle req[o] or lock[o] is low.
- No requests: gnt = 0, rom_address holds last value, ptr/owner unchanged, no pipeline entry.
- Pipeline: stage 1 register {v1, id1} captured with rom_address at grant edge; stage 2 {v2, id2} <= stage 1 next edge. rd_valid = v2 ? onehot(id2) : 0; rd_id = id2; rd_data = rom_data (pass-through, aligned with stage 2).
- No backpressure: requester must accept rd_valid whenever it occurs.
- addr slices of non-granted requesters ignored; X on them must not propagate.

## Timing
- Reset (async assert, sync-safe deassert on clock): gnt = 0, rom_address = 0, rd_valid = 0, rd_id = 0, ptr = 0, owner none, count = 0, v1 = v2 = 0. rd_data follows rom_data and is don't-care while rd_valid = 0.
- Latency: gnt in cycle T -> rom_address valid T+1 -> rd_valid/rd_data in cycle T+2. Fixed, 2 cycles.
- Throughput: one read per cycle sustained; back-to-back grants to different requesters return in grant order.
- Reset mid-operation: in-flight reads discarded; no rd_valid after reset deassert until a new grant + 2 cycles.
- Simultaneous req on all lines, no lock: grants rotate 0,1,2,3,0,... each cycle.
- Lock asserted by a requester not currently owner: takes effect only when it wins normal arbitration.

## Test plan
- Reset: hold reset_n low 3 cycles with req = 4'b1111 -> gnt = 0, rd_valid = 0, rom_address = 0; release -> first gnt = 4'b0001.
- Single requester: req[2] for one cycle with addr 9'd65, ROM model mem[65] = 8'h0E -> gnt = 4'b0100 in T, rom_address = 65 at T+1, rd_valid = 4'b0100, rd_id = 2, rd_data = 8'h0E at T+2.
- Fairness: req = 4'b1111 held 8 cycles, no lock -> gnt sequence 0,1,2,3,0,1,2,3; rd_id sequence identical, delayed 2 cycles.
- Burst: req[1], lock[1] held, req[3] held, MAX_BURST = 8, addrs 0..9 incrementing -> gnt[1] for 8 consecutive cycles, then gnt[3] one cycle, then gnt[1] resumes.
- Lock drop: same setup, lock[1] low after 3 grants -> next cycle gnt = 4'b1000.
- Mid-flight reset: grants in T and T+1, reset_n pulsed low in T+1 -> no rd_valid in T+2/T+3; all outputs at reset values.
